// File: rtl/mem_map_pkg.sv
// Shared types and constants for the MIPS data-side memory-map decoder.
package mem_map_pkg;

  // Decoder access state.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRamAcc = 2'd1,
    StIoAcc  = 2'd2,
    StErr    = 2'd3
  } state_e;

  // MARS default segment bases.
  localparam logic [31:0] MarsDataBase = 32'h1001_0000;
  localparam logic [31:0] MarsMmioBase = 32'hFFFF_0000;

  // Default region geometry (sizes in 32-bit words).
  localparam logic [31:0] DefRamBase  = MarsDataBase;
  localparam int unsigned DefRamDepth = 256;
  localparam logic [31:0] DefIoBase   = MarsMmioBase;
  localparam int unsigned DefIoDepth  = 16;
  localparam int unsigned DefIoWait   = 2;

  // True when a byte address lands on a word boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// Combinational region hit test and word index for one address window.
module mem_region_match #(
  parameter logic [31:0] Base  = 32'h0000_0000,
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = $clog2(Depth)
) (
  input  logic [31:0]     addr_i,
  output logic            hit_o,
  output logic [IdxW-1:0] idx_o
);

  // Window bounds in 33 bits so a region ending at 2^32 never wraps.
  localparam logic [32:0] Lo = {1'b0, Base};
  localparam logic [32:0] Hi = Lo + (33'(Depth) << 2);

  logic [31:0] offset;
  logic        unused_offset;

  // Hit test and byte-to-word index conversion.
  always_comb begin
    hit_o  = ({1'b0, addr_i} >= Lo) && ({1'b0, addr_i} < Hi);
    offset = addr_i - Base;
    idx_o  = offset[IdxW+1:2];
  end

  assign unused_offset = ^{offset[31:IdxW+2], offset[1:0]};

endmodule

// File: rtl/mem_map_decoder.sv
// Registered RAM / MMIO decoder with I/O wait states and a sticky fault register.
module mem_map_decoder
  import mem_map_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DefRamBase,
  parameter int unsigned RAM_DEPTH = DefRamDepth,
  parameter logic [31:0] IO_BASE   = DefIoBase,
  parameter int unsigned IO_DEPTH  = DefIoDepth,
  parameter int unsigned IO_WAIT   = DefIoWait
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ReqValid,
  input  logic                         ReqWrite,
  input  logic [31:0]                  Address,
  output logic                         ReqReady,
  output logic                         RamSel,
  output logic [$clog2(RAM_DEPTH)-1:0] RamAddress,
  output logic                         IoSel,
  output logic [$clog2(IO_DEPTH)-1:0]  IoAddress,
  output logic                         WriteEn,
  output logic                         RspValid,
  output logic                         RspError,
  input  logic                         FaultClear,
  output logic                         Fault,
  output logic [31:0]                  FaultAddress
);

  localparam int unsigned RamAw = $clog2(RAM_DEPTH);
  localparam int unsigned IoAw  = $clog2(IO_DEPTH);
  localparam int unsigned WaitW = (IO_WAIT > 0) ? $clog2(IO_WAIT + 1) : 1;

  state_e             state_q, state_d, dec_state;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               ram_sel_q, ram_sel_d;
  logic [RamAw-1:0]   ram_addr_q, ram_addr_d;
  logic               io_sel_q, io_sel_d;
  logic [IoAw-1:0]    io_addr_q, io_addr_d;
  logic               write_en_q, write_en_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d;
  logic               fault_q, fault_d;
  logic [31:0]        fault_addr_q, fault_addr_d;

  logic               ram_hit, io_hit, accept, fault_set, io_holding;
  logic [RamAw-1:0]   ram_idx;
  logic [IoAw-1:0]    io_idx;

  mem_region_match #(
    .Base  (RAM_BASE),
    .Depth (RAM_DEPTH),
    .IdxW  (RamAw)
  ) u_ram_match (
    .addr_i (Address),
    .hit_o  (ram_hit),
    .idx_o  (ram_idx)
  );

  mem_region_match #(
    .Base  (IO_BASE),
    .Depth (IO_DEPTH),
    .IdxW  (IoAw)
  ) u_io_match (
    .addr_i (Address),
    .hit_o  (io_hit),
    .idx_o  (io_idx)
  );

  // An I/O access still has wait cycles left; the bus is held and no request is taken.
  assign io_holding = (state_q == StIoAcc) && (wait_q != '0);
  assign ReqReady   = !io_holding;
  assign accept     = ReqValid && ReqReady;

  // Classify the presented address; RAM wins where the windows overlap.
  always_comb begin
    if (!is_word_aligned(Address)) begin
      dec_state = StErr;
    end else if (ram_hit) begin
      dec_state = StRamAcc;
    end else if (io_hit) begin
      dec_state = StIoAcc;
    end else begin
      dec_state = StErr;
    end
  end

  assign fault_set = accept && (dec_state == StErr);

  // Next-state, wait counter, registered strobes and fault capture.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    ram_sel_d    = 1'b0;
    ram_addr_d   = ram_addr_q;
    io_sel_d     = 1'b0;
    io_addr_d    = io_addr_q;
    write_en_d   = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_error_d  = 1'b0;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;

    if (io_holding) begin
      wait_d      = wait_q - WaitW'(1);
      io_sel_d    = 1'b1;
      write_en_d  = write_en_q;
      rsp_valid_d = (wait_q == WaitW'(1));
    end else if (accept) begin
      state_d = dec_state;
      unique case (dec_state)
        StRamAcc: begin
          ram_sel_d   = 1'b1;
          ram_addr_d  = ram_idx;
          write_en_d  = ReqWrite;
          rsp_valid_d = 1'b1;
        end
        StIoAcc: begin
          io_sel_d    = 1'b1;
          io_addr_d   = io_idx;
          write_en_d  = ReqWrite;
          wait_d      = WaitW'(IO_WAIT);
          rsp_valid_d = (IO_WAIT == 0);
        end
        default: begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end
      endcase
    end else begin
      state_d = StIdle;
    end

    // A new fault beats a simultaneous clear; the address is kept from the first fault.
    if (fault_set) begin
      fault_d = 1'b1;
      if (!fault_q || FaultClear) begin
        fault_addr_d = Address;
      end
    end else if (FaultClear) begin
      fault_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      ram_sel_q    <= 1'b0;
      ram_addr_q   <= '0;
      io_sel_q     <= 1'b0;
      io_addr_q    <= '0;
      write_en_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      ram_sel_q    <= ram_sel_d;
      ram_addr_q   <= ram_addr_d;
      io_sel_q     <= io_sel_d;
      io_addr_q    <= io_addr_d;
      write_en_q   <= write_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_error_q  <= rsp_error_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign RamSel       = ram_sel_q;
  assign RamAddress   = ram_addr_q;
  assign IoSel        = io_sel_q;
  assign IoAddress    = io_addr_q;
  assign WriteEn      = write_en_q;
  assign RspValid     = rsp_valid_q;
  assign RspError     = rsp_error_q;
  assign Fault        = fault_q;
  assign FaultAddress = fault_addr_q;

endmodule

// File: tb/tb_mem_map_decoder.sv
// Randomised self-checking bench for mem_map_decoder against a transaction-level model.
module tb_mem_map_decoder;

  localparam logic [31:0] RamBase  = 32'h1001_0000;
  localparam int          RamDepth = 256;
  localparam logic [31:0] IoBase   = 32'hFFFF_0000;
  localparam int          IoDepth  = 16;
  localparam int          IoWait   = 2;
  localparam int          SchedN   = 32;

  logic        clk;
  logic        reset;
  logic        ReqValid;
  logic        ReqWrite;
  logic [31:0] Address;
  logic        ReqReady;
  logic        RamSel;
  logic [7:0]  RamAddress;
  logic        IoSel;
  logic [3:0]  IoAddress;
  logic        WriteEn;
  logic        RspValid;
  logic        RspError;
  logic        FaultClear;
  logic        Fault;
  logic [31:0] FaultAddress;

  mem_map_decoder #(
    .RAM_BASE  (RamBase),
    .RAM_DEPTH (RamDepth),
    .IO_BASE   (IoBase),
    .IO_DEPTH  (IoDepth),
    .IO_WAIT   (IoWait)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ReqValid     (ReqValid),
    .ReqWrite     (ReqWrite),
    .Address      (Address),
    .ReqReady     (ReqReady),
    .RamSel       (RamSel),
    .RamAddress   (RamAddress),
    .IoSel        (IoSel),
    .IoAddress    (IoAddress),
    .WriteEn      (WriteEn),
    .RspValid     (RspValid),
    .RspError     (RspError),
    .FaultClear   (FaultClear),
    .Fault        (Fault),
    .FaultAddress (FaultAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bus activity for one future cycle.
  typedef struct packed {
    logic        ram_sel;
    logic        io_sel;
    logic        we;
    logic        rv;
    logic        re;
    logic [31:0] ram_idx;
    logic [31:0] io_idx;
  } exp_t;

  exp_t        sched [SchedN];
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          busy_until;
  bit          m_fault;
  logic [31:0] m_faddr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Spec-level decode: 0 = error, 1 = RAM, 2 = I/O; idx is the word index.
  function automatic int classify(input logic [31:0] a, output int idx);
    longint ua;
    ua  = longint'(a);
    idx = 0;
    if ((a % 4) != 0) return 0;
    if (ua >= longint'(RamBase) && ua < longint'(RamBase) + 4 * RamDepth) begin
      idx = int'((ua - longint'(RamBase)) / 4);
      return 1;
    end
    if (ua >= longint'(IoBase) && ua < longint'(IoBase) + 4 * IoDepth) begin
      idx = int'((ua - longint'(IoBase)) / 4);
      return 2;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SchedN; i++) sched[i] = '0;
    busy_until = 0;
    m_fault    = 1'b0;
    m_faddr    = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(ReqReady), 32'd1);
    check_eq({tag, "_ramsel"}, 32'(RamSel), 32'd0);
    check_eq({tag, "_ramaddr"}, 32'(RamAddress), 32'd0);
    check_eq({tag, "_iosel"}, 32'(IoSel), 32'd0);
    check_eq({tag, "_ioaddr"}, 32'(IoAddress), 32'd0);
    check_eq({tag, "_we"}, 32'(WriteEn), 32'd0);
    check_eq({tag, "_rv"}, 32'(RspValid), 32'd0);
    check_eq({tag, "_re"}, 32'(RspError), 32'd0);
    check_eq({tag, "_fault"}, 32'(Fault), 32'd0);
    check_eq({tag, "_faddr"}, FaultAddress, 32'd0);
  endtask

  // One cycle: check what the last edge produced, then drive the next request.
  task automatic step(input bit v, input bit w, input logic [31:0] a, input bit clr,
                      output bit acc);
    exp_t e;
    int   idx;
    int   cls;
    bit   rdy;
    @(negedge clk);
    cyc++;
    e = sched[cyc % SchedN];
    sched[cyc % SchedN] = '0;
    rdy = (cyc >= busy_until);
    check_eq("ready", 32'(ReqReady), 32'(rdy));
    check_eq("ram_sel", 32'(RamSel), 32'(e.ram_sel));
    check_eq("io_sel", 32'(IoSel), 32'(e.io_sel));
    check_eq("write_en", 32'(WriteEn), 32'(e.we));
    check_eq("rsp_valid", 32'(RspValid), 32'(e.rv));
    check_eq("rsp_error", 32'(RspError), 32'(e.re));
    if (e.ram_sel) check_eq("ram_addr", 32'(RamAddress), e.ram_idx);
    if (e.io_sel) check_eq("io_addr", 32'(IoAddress), e.io_idx);
    check_eq("fault", 32'(Fault), 32'(m_fault));
    check_eq("fault_addr", FaultAddress, m_faddr);

    acc = v && rdy;
    cls = classify(a, idx);
    if (acc) begin
      e = '0;
      if (cls == 1) begin
        e.ram_sel = 1'b1;
        e.we      = w;
        e.rv      = 1'b1;
        e.ram_idx = 32'(idx);
        sched[(cyc + 1) % SchedN] = e;
      end else if (cls == 2) begin
        for (int k = 0; k <= IoWait; k++) begin
          e        = '0;
          e.io_sel = 1'b1;
          e.we     = w;
          e.io_idx = 32'(idx);
          e.rv     = (k == IoWait);
          sched[(cyc + 1 + k) % SchedN] = e;
        end
        busy_until = cyc + 1 + IoWait;
      end else begin
        e.rv = 1'b1;
        e.re = 1'b1;
        sched[(cyc + 1) % SchedN] = e;
      end
    end
    if (acc && cls == 0) begin
      if (!m_fault || clr) m_faddr = a;
      m_fault = 1'b1;
    end else if (clr) begin
      m_fault = 1'b0;
    end

    ReqValid   = v;
    ReqWrite   = w;
    Address    = a;
    FaultClear = clr;
  endtask

  function automatic logic [31:0] gen_addr();
    case ($urandom_range(0, 9))
      0: return RamBase + 32'(4 * $urandom_range(0, RamDepth - 1));
      1: return RamBase + 32'(4 * RamDepth - 4);
      2: return RamBase + 32'(4 * RamDepth);
      3: return IoBase + 32'(4 * $urandom_range(0, IoDepth - 1));
      4: return IoBase + 32'(4 * IoDepth);
      5: return RamBase + 32'(4 * $urandom_range(0, RamDepth - 1)) + 32'($urandom_range(1, 3));
      6: return $urandom;
      7: return 32'h0000_0000;
      8: return 32'hFFFF_FFFC;
      default: return RamBase - 32'd4;
    endcase
  endfunction

  bit          acc;
  bit          pend;
  bit          pv, pw, pc;
  logic [31:0] pa;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    reset      = 1'b1;
    ReqValid   = 1'b0;
    ReqWrite   = 1'b0;
    Address    = '0;
    FaultClear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // Directed sequence from the block's bring-up list.
    step(1'b1, 1'b0, 32'h1001_0000, 1'b0, acc);
    step(1'b1, 1'b0, 32'h1001_03FC, 1'b0, acc);
    step(1'b1, 1'b0, 32'h1001_0400, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);
    step(1'b1, 1'b1, 32'hFFFF_0008, 1'b0, acc);
    for (int i = 0; i < IoWait + 1; i++) step(1'b1, 1'b0, 32'h1001_0000, 1'b0, acc);
    step(1'b1, 1'b0, 32'h1001_0004, 1'b0, acc);
    step(1'b1, 1'b0, 32'h1001_0008, 1'b0, acc);
    step(1'b1, 1'b0, 32'h1001_0002, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, acc);
    step(1'b1, 1'b0, 32'h0000_0000, 1'b1, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, acc);

    // Reset in the middle of an I/O access.
    step(1'b1, 1'b1, 32'hFFFF_0008, 1'b0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, acc);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < IoWait + 2; i++) step(1'b0, 1'b0, 32'h0, 1'b0, acc);

    // Random traffic; a stalled request is held until taken.
    pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        pv = ($urandom_range(0, 3) != 0);
        pw = $urandom_range(0, 1) == 1;
        pa = gen_addr();
      end
      pc = ($urandom_range(0, 15) == 0);
      step(pv, pw, pa, pc, acc);
      pend = pv && !acc;
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_map_decoder.md
# mem_map_decoder

Registered memory-map decoder for the pipelined MIPS data path, between the MEM stage and the data RAM / memory-mapped I/O. It maps MARS byte addresses to word indices for a parametrised RAM region and a parametrised I/O region, inserts programmable I/O wait states with a ready/valid handshake, and flags out-of-range or misaligned accesses in a sticky fault register.

## Interface
- RAM_BASE, 32'h10010000, byte base address of data RAM
- RAM_DEPTH, 256, RAM size in 32-bit words, power of two
- IO_BASE, 32'hFFFF0000, byte base address of I/O region
- IO_DEPTH, 16, I/O size in words, power of two
- IO_WAIT, 2, extra cycles an I/O access holds the bus (0 allowed)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  MEM stage presents an access
- ReqWrite  in  1  access is a store
- Address  in  32  byte address
- ReqReady  out  1  request accepted this cycle when ReqValid&&ReqReady
- RamSel  out  1  RAM access strobe
- RamAddress  out  clog2(RAM_DEPTH)  RAM word index
- IoSel  out  1  I/O access strobe, held for the full I/O access
- IoAddress  out  clog2(IO_DEPTH)  I/O word index
- WriteEn  out  1  registered ReqWrite, qualified by RamSel or IoSel
- RspValid  out  1  one-cycle completion pulse
- RspError  out  1  completion was a fault (valid with RspValid)
- FaultClear  in  1  clears sticky fault
- Fault  out  1  sticky fault flag
- FaultAddress  out  32  address of the fault that set Fault

## Operation
- States: IDLE, RAM_ACC, IO_ACC, ERR.
- ReqReady = 1 in IDLE, RAM_ACC, ERR; 0 in IO_ACC except its final cycle.
- On accept, decode in order: Address[1:0]!=0 → ERR; RAM hit → RAM_ACC; I/O hit → IO_ACC; else → ERR. RAM wins if regions overlap.
- Hit test in 33-bit unsigned arithmetic: BASE <= Address < BASE + 4*DEPTH; no wrap at 2^32.
- Index = (Address − BASE) >> 2, truncated to index width.
- RAM_ACC: RamSel=1, RamAddress, WriteEn, RspValid=1 for one cycle; next accepted request goes straight to its state, else IDLE.
- IO_ACC: wait counter loaded with IO_WAIT; IoSel, IoAddress, WriteEn held; counter decrements; RspValid on the cycle counter = 0, then proceed as RAM_ACC.
- ERR: RspValid=1, RspError=1 for one cycle, no strobes; Fault set.
- FaultAddress captured only when Fault is 0 or being cleared in the same cycle; a new fault coinciding with FaultClear wins (Fault stays 1, new address captured).

## Timing
- Reset values: state IDLE, RamSel=IoSel=WriteEn=RspValid=RspError=Fault=0, RamAddress=IoAddress=0, FaultAddress=0, counter 0, ReqReady=1.
- Latency: request accepted at cycle N → strobes and RspValid at N+1 (RAM, ERR); I/O strobes N+1..N+1+IO_WAIT, RspValid at N+1+IO_WAIT.
- Throughput: one RAM access per cycle; I/O accesses back-to-back separated by IO_WAIT stall cycles.
- ReqValid while ReqReady=0 is ignored; the requester holds it.
- Reset mid-access: all outputs return to reset values asynchronously; the pending access produces no RspValid.
- All outputs registered; no combinational path from Address to any output except none (ReqReady depends on state only).

## Structure
- Shared package mem_map_pkg: state enum, default base/depth constants, MARS segment constants.
- One sub-module: mem_region_match (parametrised BASE/DEPTH; combinational hit flag and word index), instantiated twice.

## Test plan
- Read 0x10010000 → N+1: RamSel=1, RamAddress=0, RspValid=1; read 0x100103FC → RamAddress=255.
- Read 0x10010400 → RspValid=1, RspError=1, Fault=1, FaultAddress=0x10010400, no strobes.
- Store 0xFFFF0008 (IO_WAIT=2) → IoSel=1, IoAddress=2, WriteEn=1 for cycles N+1..N+3, ReqReady=0 on N+1..N+2, RspValid only at N+3.
- Three consecutive RAM reads 0x10010000/04/08 → RspValid on three consecutive cycles, RamAddress 0,1,2.
- Misaligned 0x10010002 sets Fault; later FaultClear with fault 0x00000000 in same cycle → Fault=1, FaultAddress=0x00000000; FaultClear alone → Fault=0.
- Assert reset during IO_ACC cycle N+2 → all outputs at reset values immediately, no RspValid after reset release.
